// File: rtl/log2_stream_if.sv
// log2_stream_if: operand and result valid/ready channels for log2_stream
interface log2_stream_if #(
    parameter int WIDTH = 32
);
    localparam int IDX_W = $clog2(WIDTH) + 1;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_num;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_degree;
    logic             out_zero;
    logic             out_pow2;
    logic             out_err;
    modport master (
        output in_valid, in_num, in_mode, out_ready,
        input  in_ready, out_valid, out_degree, out_zero, out_pow2, out_err
    );
    modport slave (
        input  in_valid, in_num, in_mode, out_ready,
        output in_ready, out_valid, out_degree, out_zero, out_pow2, out_err
    );
endinterface

// File: rtl/log2_stream.sv
// log2_stream: two-stage valid/ready pipeline returning floor/ceil log2 or LSB index
module log2_stream #(
    parameter int WIDTH = 32
) (
    input logic clk,
    input logic rst,
    log2_stream_if.slave s
);
    localparam int IDX_W = $clog2(WIDTH) + 1;
    logic             s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] num_q, num_d;
    logic [1:0]       mode_q, mode_d;
    logic [IDX_W-1:0] degree_q, degree_d, msb, lsb, ceil_idx, degree;
    logic             zero_q, zero_d, pow2_q, pow2_d, err_q, err_d;
    logic             zero, pow2, s2_load, in_fire;
    always_comb begin
        msb = '0;
        lsb = '0;
        for (int i = 0; i < WIDTH; i++) msb = num_q[i] ? IDX_W'(i) : msb;
        for (int i = WIDTH - 1; i >= 0; i--) lsb = num_q[i] ? IDX_W'(i) : lsb;
        zero = num_q == '0;
        pow2 = !zero && (num_q & (num_q - WIDTH'(1))) == '0;
        ceil_idx = pow2 ? msb : msb + IDX_W'(1);
        degree = (mode_q == 2'd3 || zero) ? '0 :
                 mode_q == 2'd0 ? msb :
                 mode_q == 2'd1 ? ceil_idx : lsb;
    end
    always_comb begin
        s2_load = s1_valid_q && (!s2_valid_q || s.out_ready);
        s.in_ready = !s1_valid_q || s2_load;
        in_fire = s.in_valid && s.in_ready;
        s1_valid_d = in_fire || (s1_valid_q && !s2_load);
        s2_valid_d = s2_load || (s2_valid_q && !s.out_ready);
        num_d = in_fire ? s.in_num : num_q;
        mode_d = in_fire ? s.in_mode : mode_q;
        degree_d = s2_load ? degree : degree_q;
        zero_d = s2_load ? zero : zero_q;
        pow2_d = s2_load ? pow2 : pow2_q;
        err_d = s2_load ? mode_q == 2'd3 : err_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            degree_q <= '0;
            zero_q <= 1'b0;
            pow2_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            degree_q <= degree_d;
            zero_q <= zero_d;
            pow2_q <= pow2_d;
            err_q <= err_d;
        end
    end
    always_ff @(posedge clk) begin
        num_q <= num_d;
        mode_q <= mode_d;
    end
    assign s.out_valid = s2_valid_q;
    assign s.out_degree = degree_q;
    assign s.out_zero = zero_q;
    assign s.out_pow2 = pow2_q;
    assign s.out_err = err_q;
endmodule

// File: tb/tb_log2_stream.sv
// tb_log2_stream: directed and streaming checks on WIDTH=32, 8 and 5 instances driven in lockstep
module tb_log2_stream;
    logic clk = 1'b0;
    logic rst, v, ordy;
    logic [31:0] num;
    logic [1:0] mode;
    logic [8:0] o32, o8, o5;
    int checks = 0;
    int failures = 0;
    always #5 clk = ~clk;
    log2_stream_if #(.WIDTH(32)) i32 ();
    log2_stream_if #(.WIDTH(8)) i8 ();
    log2_stream_if #(.WIDTH(5)) i5 ();
    assign i32.in_valid = v;
    assign i8.in_valid = v;
    assign i5.in_valid = v;
    assign i32.in_num = num;
    assign i8.in_num = num[7:0];
    assign i5.in_num = num[4:0];
    assign i32.in_mode = mode;
    assign i8.in_mode = mode;
    assign i5.in_mode = mode;
    assign i32.out_ready = ordy;
    assign i8.out_ready = ordy;
    assign i5.out_ready = ordy;
    assign o32 = {6'(i32.out_degree), i32.out_zero, i32.out_pow2, i32.out_err};
    assign o8 = {6'(i8.out_degree), i8.out_zero, i8.out_pow2, i8.out_err};
    assign o5 = {6'(i5.out_degree), i5.out_zero, i5.out_pow2, i5.out_err};
    log2_stream #(.WIDTH(32)) d32 (.clk(clk), .rst(rst), .s(i32));
    log2_stream #(.WIDTH(8)) d8 (.clk(clk), .rst(rst), .s(i8));
    log2_stream #(.WIDTH(5)) d5 (.clk(clk), .rst(rst), .s(i5));

    function automatic logic [8:0] model(input logic [31:0] x, input logic [1:0] m, input int w);
        logic [31:0] xv, t;
        logic [63:0] p;
        int fl, ce, lb;
        xv = w == 32 ? x : x & ((32'd1 << w) - 32'd1);
        fl = 0;
        ce = 0;
        lb = 0;
        p = 64'd1;
        t = xv;
        while (t > 32'd1) begin t = t >> 1; fl++; end
        while (p < {32'd0, xv}) begin p = p << 1; ce++; end
        t = xv;
        if (t != 32'd0) while (!t[0]) begin t = t >> 1; lb++; end
        return {(m == 2'd3 || xv == 32'd0) ? 6'd0 : m == 2'd0 ? 6'(fl) : m == 2'd1 ? 6'(ce) : 6'(lb),
                xv == 32'd0, $countones(xv) == 1, m == 2'd3};
    endfunction

    task automatic send_op(input logic [31:0] n, input logic [1:0] m, output logic [2:0] ev,
                           output logic [2:0] lv, output logic [8:0] r32, output logic [8:0] r8,
                           output logic [8:0] r5);
        @(negedge clk);
        v = 1'b1;
        num = n;
        mode = m;
        ordy = 1'b1;
        @(negedge clk);
        v = 1'b0;
        ev = {i32.out_valid, i8.out_valid, i5.out_valid};
        @(negedge clk);
        lv = {i32.out_valid, i8.out_valid, i5.out_valid};
        r32 = o32;
        r8 = o8;
        r5 = o5;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        v = 1'b0;
        ordy = 1'b0;
        num = '0;
        mode = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({i32.out_valid, i8.out_valid, i5.out_valid} !== 3'b000) begin
            failures++;
            $display("FAIL reset_valid got=%b exp=000", {i32.out_valid, i8.out_valid, i5.out_valid});
        end
        checks++;
        if ({i32.in_ready, i8.in_ready, i5.in_ready} !== 3'b111) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=111", {i32.in_ready, i8.in_ready, i5.in_ready});
        end
        checks++;
        if ({o32, o8, o5} !== 27'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", {o32, o8, o5});
        end
    endtask

    task automatic test_directed();
        logic [60:0] tab [17];
        logic [2:0] ev, lv;
        logic [8:0] r32, r8, r5;
        tab[0]  = {32'h40, 2'd0, 9'b000110_010, 9'b000110_010, 9'b000000_100};
        tab[1]  = {32'h40, 2'd1, 9'b000110_010, 9'b000110_010, 9'b000000_100};
        tab[2]  = {32'h40, 2'd2, 9'b000110_010, 9'b000110_010, 9'b000000_100};
        tab[3]  = {32'h148, 2'd0, 9'b001000_000, 9'b000110_000, 9'b000011_010};
        tab[4]  = {32'h148, 2'd1, 9'b001001_000, 9'b000111_000, 9'b000011_010};
        tab[5]  = {32'h148, 2'd2, 9'b000011_000, 9'b000011_000, 9'b000011_010};
        tab[6]  = {32'h8000_0001, 2'd1, 9'b100000_000, 9'b000000_010, 9'b000000_010};
        tab[7]  = {32'h8000_0001, 2'd2, 9'b000000_000, 9'b000000_010, 9'b000000_010};
        tab[8]  = {32'h0, 2'd0, 9'b000000_100, 9'b000000_100, 9'b000000_100};
        tab[9]  = {32'h0, 2'd1, 9'b000000_100, 9'b000000_100, 9'b000000_100};
        tab[10] = {32'h0, 2'd2, 9'b000000_100, 9'b000000_100, 9'b000000_100};
        tab[11] = {32'h10, 2'd3, 9'b000000_011, 9'b000000_011, 9'b000000_011};
        tab[12] = {32'h11, 2'd0, 9'b000100_000, 9'b000100_000, 9'b000100_000};
        tab[13] = {32'h11, 2'd1, 9'b000101_000, 9'b000101_000, 9'b000101_000};
        tab[14] = {32'hFF, 2'd1, 9'b001000_000, 9'b001000_000, 9'b000101_000};
        tab[15] = {32'h1, 2'd2, 9'b000000_010, 9'b000000_010, 9'b000000_010};
        tab[16] = {32'hFFFF_FFFF, 2'd0, 9'b011111_000, 9'b000111_000, 9'b000100_000};
        for (int k = 0; k < 17; k++) begin
            send_op(tab[k][60:29], tab[k][28:27], ev, lv, r32, r8, r5);
            checks++;
            if (ev !== 3'b000) begin
                failures++;
                $display("FAIL directed[%0d]_early_valid got=%b exp=000", k, ev);
            end
            checks++;
            if (lv !== 3'b111) begin
                failures++;
                $display("FAIL directed[%0d]_latency got=%b exp=111", k, lv);
            end
            checks++;
            if (r32 !== tab[k][26:18]) begin
                failures++;
                $display("FAIL directed[%0d]_w32 got=%h exp=%h", k, r32, tab[k][26:18]);
            end
            checks++;
            if (r8 !== tab[k][17:9]) begin
                failures++;
                $display("FAIL directed[%0d]_w8 got=%h exp=%h", k, r8, tab[k][17:9]);
            end
            checks++;
            if (r5 !== tab[k][8:0]) begin
                failures++;
                $display("FAIL directed[%0d]_w5 got=%h exp=%h", k, r5, tab[k][8:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic ev;
        logic [8:0] e32, e8, e5;
        ordy = 1'b1;
        for (int c = 0; c < 19; c++) begin
            @(negedge clk);
            ev = c >= 2 && c < 18;
            e32 = {6'(c - 2), 3'b010};
            e8 = c - 2 < 8 ? {6'(c - 2), 3'b010} : 9'b000000_100;
            e5 = c - 2 < 5 ? {6'(c - 2), 3'b010} : 9'b000000_100;
            checks++;
            if ({i32.out_valid, i8.out_valid, i5.out_valid} !== {3{ev}}) begin
                failures++;
                $display("FAIL burst_valid[%0d] got=%b exp=%b", c, {i32.out_valid, i8.out_valid, i5.out_valid}, {3{ev}});
            end
            if (ev) begin
                checks++;
                if ({o32, o8, o5} !== {e32, e8, e5}) begin
                    failures++;
                    $display("FAIL burst_result[%0d] got=%h exp=%h", c, {o32, o8, o5}, {e32, e8, e5});
                end
            end
            checks++;
            if ({i32.in_ready, i8.in_ready, i5.in_ready} !== 3'b111) begin
                failures++;
                $display("FAIL burst_ready[%0d] got=%b exp=111", c, {i32.in_ready, i8.in_ready, i5.in_ready});
            end
            v = c < 16;
            num = 32'd1 << c;
            mode = 2'd0;
        end
    endtask

    task automatic test_stream();
        logic [8:0] q32[$], q8[$], q5[$];
        logic [8:0] e32, e8, e5;
        logic [27:0] held;
        logic stall, exp_rdy;
        int acc, cyc;
        stall = 1'b0;
        held = '0;
        acc = 0;
        cyc = 0;
        while ((acc < 64 || q32.size() > 0) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (stall) begin
                checks++;
                if ({i32.out_valid, o32, o8, o5} !== held) begin
                    failures++;
                    $display("FAIL stream_stable got=%h exp=%h", {i32.out_valid, o32, o8, o5}, held);
                end
            end
            v = acc < 64 ? 1'($urandom_range(0, 1)) : 1'b0;
            ordy = acc < 64 ? 1'($urandom_range(0, 1)) : 1'b1;
            num = $urandom >> $urandom_range(0, 31);
            mode = 2'($urandom_range(0, 3));
            #1;
            exp_rdy = !(q32.size() == 2 && !ordy);
            checks++;
            if ({i32.in_ready, i8.in_ready, i5.in_ready} !== {3{exp_rdy}}) begin
                failures++;
                $display("FAIL stream_ready got=%b exp=%b", {i32.in_ready, i8.in_ready, i5.in_ready}, {3{exp_rdy}});
            end
            checks++;
            if ({i8.out_valid, i5.out_valid} !== {2{i32.out_valid}}) begin
                failures++;
                $display("FAIL stream_valid_lockstep got=%b exp=%b", {i8.out_valid, i5.out_valid}, {2{i32.out_valid}});
            end
            if (i32.out_valid && ordy) begin
                checks++;
                if (q32.size() == 0) begin
                    failures++;
                    $display("FAIL stream_extra_output got=%h exp=none", o32);
                end else begin
                    e32 = q32.pop_front();
                    e8 = q8.pop_front();
                    e5 = q5.pop_front();
                    if ({o32, o8, o5} !== {e32, e8, e5}) begin
                        failures++;
                        $display("FAIL stream_result got=%h exp=%h", {o32, o8, o5}, {e32, e8, e5});
                    end
                end
            end
            if (v && i32.in_ready) begin
                q32.push_back(model(num, mode, 32));
                q8.push_back(model(num, mode, 8));
                q5.push_back(model(num, mode, 5));
                acc++;
            end
            stall = i32.out_valid && !ordy;
            held = {i32.out_valid, o32, o8, o5};
        end
        checks++;
        if (acc !== 64 || q32.size() !== 0) begin
            failures++;
            $display("FAIL stream_done got=%0d/%0d exp=64/0", acc, q32.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [2:0] ev, lv;
        logic [8:0] r32, r8, r5;
        @(negedge clk);
        v = 1'b1;
        ordy = 1'b0;
        num = 32'h55;
        mode = 2'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({i32.in_ready, i32.out_valid} !== 2'b01) begin
            failures++;
            $display("FAIL mid_full got=%b exp=01", {i32.in_ready, i32.out_valid});
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        v = 1'b0;
        checks++;
        if ({i32.out_valid, i8.out_valid, i5.out_valid, i32.in_ready, i8.in_ready, i5.in_ready} !== 6'b000111) begin
            failures++;
            $display("FAIL mid_reset_ctrl got=%b exp=000111",
                     {i32.out_valid, i8.out_valid, i5.out_valid, i32.in_ready, i8.in_ready, i5.in_ready});
        end
        checks++;
        if ({o32, o8, o5} !== 27'd0) begin
            failures++;
            $display("FAIL mid_reset_outputs got=%h exp=0", {o32, o8, o5});
        end
        send_op(32'h3, 2'd0, ev, lv, r32, r8, r5);
        checks++;
        if ({ev, lv} !== 6'b000111) begin
            failures++;
            $display("FAIL mid_recover_valid got=%b exp=000111", {ev, lv});
        end
        checks++;
        if ({r32, r8, r5} !== {3{9'b000001_000}}) begin
            failures++;
            $display("FAIL mid_recover_result got=%h exp=%h", {r32, r8, r5}, {3{9'b000001_000}});
        end
        @(negedge clk);
        checks++;
        if ({i32.out_valid, i8.out_valid, i5.out_valid} !== 3'b000) begin
            failures++;
            $display("FAIL mid_stale got=%b exp=000", {i32.out_valid, i8.out_valid, i5.out_valid});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_stream();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
